// File: rtl/lcd_video_timing.sv
// RGB LCD timing generator with HS/VS/DE, frame-buffer read port, built-in test
// patterns and RGB565 expansion; all panel outputs share one RD_LAT+2 pipeline.
module lcd_video_timing #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 210,
    parameter int unsigned H_SYNC   = 1,
    parameter int unsigned H_BP     = 182,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 45,
    parameter int unsigned V_SYNC   = 1,
    parameter int unsigned V_BP     = 8,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned COLOR_W  = 6,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic               lcd_clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [15:0]        solid_rgb,
    output logic               pix_rd,
    output logic [ADDR_W-1:0]  pix_addr,
    input  logic [15:0]        pix_data,
    output logic               lcd_hs,
    output logic               lcd_vs,
    output logic               lcd_de,
    output logic [COLOR_W-1:0] lcd_r,
    output logic [COLOR_W-1:0] lcd_g,
    output logic [COLOR_W-1:0] lcd_b,
    output logic               frame_start
);

    localparam int unsigned H_TOTAL   = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL   = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned H_A_START = H_SYNC + H_BP;
    localparam int unsigned H_A_END   = H_A_START + H_ACTIVE;
    localparam int unsigned V_A_START = V_SYNC + V_BP;
    localparam int unsigned V_A_END   = V_A_START + V_ACTIVE;
    localparam int unsigned HW_RAW    = $clog2(H_TOTAL + 1);
    localparam int unsigned VW_RAW    = $clog2(V_TOTAL + 1);
    localparam int unsigned HW        = (HW_RAW > 5) ? HW_RAW : 5;
    localparam int unsigned VW        = (VW_RAW > 5) ? VW_RAW : 5;
    localparam int unsigned BAR_W     = H_ACTIVE / 8;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic        ext;
        logic [15:0] rgb;
    } pipe_t;

    logic [HW-1:0]     h_q, h_d, x;
    logic [VW-1:0]     v_q, v_d, y;
    logic              en_q;
    logic [1:0]        mode_q;
    logic [15:0]       solid_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] pix_addr_q;
    logic              h_last, v_last, frame_wrap, h_act, v_act;
    logic [2:0]        bar;
    logic              grid_on;
    pipe_t             stage_d;
    pipe_t             pipe_q [RD_LAT+1];
    pipe_t             tail;
    logic [15:0]       px;

    logic              hs_q, vs_q, de_q, fs_q;
    logic [COLOR_W-1:0] r_q, g_q, b_q;

    // MSB-aligned expansion, low bits refilled from the channel's own MSBs
    function automatic logic [COLOR_W-1:0] exp5(input logic [4:0] c);
        logic [9:0] rep;
        rep = {c, c};
        return rep[9 -: COLOR_W];
    endfunction

    function automatic logic [COLOR_W-1:0] exp6(input logic [5:0] c);
        logic [11:0] rep;
        rep = {c, c};
        return rep[11 -: COLOR_W];
    endfunction

    always_comb begin
        h_last     = (h_q == HW'(H_TOTAL - 1));
        v_last     = (v_q == VW'(V_TOTAL - 1));
        frame_wrap = h_last && v_last;
        h_d        = h_last ? '0 : h_q + HW'(1);
        v_d        = v_q;
        if (h_last) v_d = v_last ? '0 : v_q + VW'(1);
        h_act      = (h_q >= HW'(H_A_START)) && (h_q < HW'(H_A_END));
        v_act      = (v_q >= VW'(V_A_START)) && (v_q < VW'(V_A_END));
        x          = h_q - HW'(H_A_START);
        y          = v_q - VW'(V_A_START);

        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x >= HW'(k * BAR_W)) bar = 3'(k);
        end
        grid_on = (x[4:0] == 5'd0) || (y[4:0] == 5'd0) ||
                  (x == HW'(H_ACTIVE - 1)) || (y == VW'(V_ACTIVE - 1));

        stage_d     = '0;
        stage_d.hs  = (h_q < HW'(H_SYNC));
        stage_d.vs  = (v_q < VW'(V_SYNC));
        stage_d.de  = h_act && v_act && en_q;
        stage_d.fs  = (h_q == '0) && (v_q == '0);
        stage_d.ext = (mode_q == 2'b00);
        case (mode_q)
            2'b01: begin
                case (bar)
                    3'd0:    stage_d.rgb = 16'hFFFF;
                    3'd1:    stage_d.rgb = 16'hFFE0;
                    3'd2:    stage_d.rgb = 16'h07FF;
                    3'd3:    stage_d.rgb = 16'h07E0;
                    3'd4:    stage_d.rgb = 16'hF81F;
                    3'd5:    stage_d.rgb = 16'hF800;
                    3'd6:    stage_d.rgb = 16'h001F;
                    default: stage_d.rgb = 16'h0000;
                endcase
            end
            2'b10:   stage_d.rgb = grid_on ? 16'hFFFF : 16'h0000;
            2'b11:   stage_d.rgb = solid_q;
            default: stage_d.rgb = 16'h0000;
        endcase
        rd_d = stage_d.de && stage_d.ext;
    end

    // Counters, frame-latched controls and the linear read address
    always_ff @(posedge lcd_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q        <= '0;
            v_q        <= '0;
            en_q       <= 1'b0;
            mode_q     <= 2'b00;
            solid_q    <= '0;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            pix_addr_q <= '0;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            rd_q <= rd_d;
            if (frame_wrap) begin
                en_q    <= enable;
                mode_q  <= mode;
                solid_q <= solid_rgb;
            end
            if (stage_d.fs) begin
                addr_q <= '0;
            end else if (rd_d) begin
                pix_addr_q <= addr_q;
                addr_q     <= addr_q + ADDR_W'(1);
            end
        end
    end

    assign tail = pipe_q[RD_LAT];
    assign px   = tail.ext ? pix_data : tail.rgb;

    // Delay line matching the frame-buffer latency, then the panel output register
    always_ff @(posedge lcd_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= int'(RD_LAT); k++) pipe_q[k] <= '0;
            hs_q <= 1'b0;
            vs_q <= 1'b0;
            de_q <= 1'b0;
            fs_q <= 1'b0;
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
        end else begin
            pipe_q[0] <= stage_d;
            for (int k = 1; k <= int'(RD_LAT); k++) pipe_q[k] <= pipe_q[k-1];
            hs_q <= tail.hs;
            vs_q <= tail.vs;
            de_q <= tail.de;
            fs_q <= tail.fs;
            r_q  <= tail.de ? exp5(px[15:11]) : '0;
            g_q  <= tail.de ? exp6(px[10:5])  : '0;
            b_q  <= tail.de ? exp5(px[4:0])   : '0;
        end
    end

    assign pix_rd      = rd_q;
    assign pix_addr    = pix_addr_q;
    assign lcd_hs      = hs_q ? HS_POL : ~HS_POL;
    assign lcd_vs      = vs_q ? VS_POL : ~VS_POL;
    assign lcd_de      = de_q;
    assign frame_start = fs_q;
    assign lcd_r       = r_q;
    assign lcd_g       = g_q;
    assign lcd_b       = b_q;

endmodule

// File: tb/tb_lcd_video_timing.sv
// Directed bench for lcd_video_timing: small 15x8 raster, plus a COLOR_W=8 instance.
module tb_lcd_video_timing;

    logic        lcd_clk;
    logic        rst_n;
    logic        enable;
    logic [1:0]  mode;
    logic [15:0] solid_rgb;
    logic        pix_rd;
    logic [7:0]  pix_addr;
    logic [15:0] pix_data;
    logic        lcd_hs, lcd_vs, lcd_de, frame_start;
    logic [5:0]  lcd_r, lcd_g, lcd_b;

    logic        pix_rd8;
    logic [7:0]  pix_addr8;
    logic [15:0] pix_data8;
    logic        hs8, vs8, de8, fs8;
    logic [7:0]  r8, g8, b8;

    logic [15:0] mem_d1;

    int n_checks = 0;
    int n_errors = 0;

    lcd_video_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(2), .COLOR_W(6), .ADDR_W(8)
    ) u_dut (
        .lcd_clk(lcd_clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .solid_rgb(solid_rgb), .pix_rd(pix_rd), .pix_addr(pix_addr),
        .pix_data(pix_data), .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de),
        .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b), .frame_start(frame_start)
    );

    lcd_video_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(2), .COLOR_W(8), .ADDR_W(8)
    ) u_dut8 (
        .lcd_clk(lcd_clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .solid_rgb(solid_rgb), .pix_rd(pix_rd8), .pix_addr(pix_addr8),
        .pix_data(pix_data8), .lcd_hs(hs8), .lcd_vs(vs8), .lcd_de(de8),
        .lcd_r(r8), .lcd_g(g8), .lcd_b(b8), .frame_start(fs8)
    );

    initial lcd_clk = 1'b0;
    always #5 lcd_clk = ~lcd_clk;

    // Frame buffer whose content equals the address, two-cycle read latency
    always @(posedge lcd_clk) begin
        mem_d1   <= pix_rd ? 16'(pix_addr) : 16'hBAD0;
        pix_data <= mem_d1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    int de_cnt [8];
    int rd_cnt [8];
    int fs_cnt [8];
    int rise_cnt [8];
    int hs_lo, vs_lo, bad_solid, exp_addr, first_rd_s, de_rise_s;
    logic prev_de;

    task automatic clear_stats();
        for (int i = 0; i < 8; i++) begin
            de_cnt[i] = 0; rd_cnt[i] = 0; fs_cnt[i] = 0; rise_cnt[i] = 0;
        end
        hs_lo = 0; vs_lo = 0; bad_solid = 0; exp_addr = 0;
        first_rd_s = -1; de_rise_s = -1; prev_de = 1'b0;
    endtask

    // One sample per cycle; output state lags the read strobe by 3 samples
    task automatic sample(input int s);
        int fo;
        int fr;
        fo = (s >= 3) ? (s - 3) / 120 : -1;
        fr = s / 120;
        if (fo >= 0 && fo < 8) begin
            if (lcd_de) de_cnt[fo]++;
            if (frame_start) fs_cnt[fo]++;
            if (lcd_de && !prev_de) begin
                rise_cnt[fo]++;
                if (fo == 1 && de_rise_s < 0) de_rise_s = s;
            end
            if (fo == 0 && !lcd_hs) hs_lo++;
            if (fo == 0 && !lcd_vs) vs_lo++;
            if (fo == 3 && lcd_de && (lcd_r != 6'd63 || lcd_g != 6'd0 || lcd_b != 6'd0))
                bad_solid++;
        end
        if (s % 120 == 0) exp_addr = 0;
        if (pix_rd && fr < 8) begin
            rd_cnt[fr]++;
            if (fr == 1 && first_rd_s < 0) first_rd_s = s;
            chk("pix_addr_seq", 32'(pix_addr), 32'(exp_addr));
            exp_addr++;
        end
        prev_de = lcd_de;
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b1;
        mode      = 2'b00;
        solid_rgb = 16'h0000;
        pix_data8 = 16'h8410;
        clear_stats();

        repeat (3) @(posedge lcd_clk);
        @(negedge lcd_clk);
        chk("rst_hs", 32'(lcd_hs), 32'd1);
        chk("rst_vs", 32'(lcd_vs), 32'd1);
        chk("rst_de", 32'(lcd_de), 32'd0);
        chk("rst_rgb", 32'({lcd_r, lcd_g, lcd_b}), 32'd0);
        chk("rst_rd", 32'(pix_rd), 32'd0);
        chk("rst_addr", 32'(pix_addr), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        rst_n = 1'b1;

        for (int s = 0; s <= 775; s++) begin
            @(negedge lcd_clk);
            sample(s);
            case (s)
                178: begin
                    chk("ext_px5_b", 32'(lcd_b), 32'h0A);
                    chk("ext_px5_rg", 32'({lcd_r, lcd_g}), 32'd0);
                    chk("w8_r", 32'(r8), 32'h84);
                    chk("w8_g", 32'(g8), 32'h82);
                    chk("w8_b", 32'(b8), 32'h84);
                end
                300: begin
                    mode      = 2'b11;
                    solid_rgb = 16'hF800;
                end
                345: begin
                    chk("switch_keep_ext_b", 32'(lcd_b), 32'd63);
                    chk("switch_keep_ext_r", 32'(lcd_r), 32'd0);
                end
                420: mode = 2'b01;
                534: chk("bars_x1", 32'({lcd_r, lcd_g, lcd_b}), {14'd0, 6'd63, 6'd63, 6'd0});
                540: mode = 2'b10;
                570: begin
                    chk("bars_x7_de", 32'(lcd_de), 32'd1);
                    chk("bars_x7", 32'({lcd_r, lcd_g, lcd_b}), 32'd0);
                end
                660: mode = 2'b00;
                671: chk("grid_x3y1", 32'(lcd_r), 32'd0);
                675: chk("grid_x7y1", 32'(lcd_r), 32'd63);
                775: begin
                    chk("pre_rst_de", 32'(lcd_de), 32'd1);
                    chk("pre_rst_rd", 32'(pix_rd), 32'd1);
                    #1 rst_n = 1'b0;
                    #1;
                    chk("mid_rst_de", 32'(lcd_de), 32'd0);
                    chk("mid_rst_rgb", 32'({lcd_r, lcd_g, lcd_b}), 32'd0);
                    chk("mid_rst_rd", 32'(pix_rd), 32'd0);
                    chk("mid_rst_sync", 32'({lcd_hs, lcd_vs}), 32'd3);
                end
                default: ;
            endcase
        end

        chk("f0_hs_low", 32'(hs_lo), 32'd16);
        chk("f0_vs_low", 32'(vs_lo), 32'd15);
        chk("f0_fs", 32'(fs_cnt[0]), 32'd1);
        chk("f1_fs", 32'(fs_cnt[1]), 32'd1);
        chk("f0_de", 32'(de_cnt[0]), 32'd0);
        chk("f0_rd", 32'(rd_cnt[0]), 32'd0);
        chk("f1_de", 32'(de_cnt[1]), 32'd32);
        chk("f1_de_lines", 32'(rise_cnt[1]), 32'd4);
        chk("f1_rd", 32'(rd_cnt[1]), 32'd32);
        chk("de_after_rd", 32'(de_rise_s - first_rd_s), 32'd3);
        chk("f2_rd", 32'(rd_cnt[2]), 32'd32);
        chk("f3_de", 32'(de_cnt[3]), 32'd32);
        chk("f3_solid_bad", 32'(bad_solid), 32'd0);
        chk("f3_rd", 32'(rd_cnt[3]), 32'd0);
        chk("f4_rd", 32'(rd_cnt[4]), 32'd0);

        repeat (3) @(posedge lcd_clk);
        @(negedge lcd_clk);
        rst_n = 1'b1;
        clear_stats();
        for (int s = 0; s <= 250; s++) begin
            @(negedge lcd_clk);
            sample(s);
        end
        chk("rr_f0_de", 32'(de_cnt[0]), 32'd0);
        chk("rr_f0_rd", 32'(rd_cnt[0]), 32'd0);
        chk("rr_f1_de", 32'(de_cnt[1]), 32'd32);
        chk("rr_f1_rd", 32'(rd_cnt[1]), 32'd32);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
